branch_predictor: RTL and testbench
===================================

# branch_predictor

Dynamic direction predictor paired with the PC-select logic: it supplies the `prediction` bit for the branch currently in fetch and, at the execute end, resolves that branch, raises `misprediction` and trains its table. It holds a branch history table (BHT) of 2-bit saturating counters indexed by PC. It also keeps a global history register and two performance counters.

## Interface
- `BHT_ENTRIES`, 64, number of counters; power of two, 4..1024
- `INDEX_BITS`, $clog2(BHT_ENTRIES), BHT index width (derived, not overridden)
- `clk`  input  1  single clock, all state updates on rising edge
- `rst`  input  1  asynchronous, active-high reset
- `IF_PC`  input  32  fetch PC to look up
- `prediction`  output  1  predicted taken for `IF_PC`; goes down the pipe with the instruction
- `IF_index`  output  INDEX_BITS  BHT index used for `prediction`; goes down the pipe
- `EXE_valid`  input  1  EXE stage holds a real, non-stalled, non-flushed instruction
- `EXE_branch`  input  2  flow-control class: 00 none, 01 conditional branch, 10 jal, 11 jalr
- `EXE_prediction`  input  1  `prediction` carried from fetch
- `EXE_index`  input  INDEX_BITS  `IF_index` carried from fetch
- `EXE_taken`  input  1  resolved branch outcome from the comparator
- `misprediction`  output  1  resolved direction differs from the predicted one
- `branch_count`  output  32  resolved conditional branches since reset
- `mispredict_count`  output  32  mispredictions since reset

## Operation
- Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T. A counter predicts taken when its MSB is 1.
- Lookup: `IF_index` = `IF_PC[INDEX_BITS+1:2]` (base mode). `prediction` = MSB of `bht[IF_index]`. This path is purely combinational.
- Resolve: `resolve` = `EXE_valid` && `EXE_branch`==01. `misprediction` = `resolve` && (`EXE_taken` != `EXE_prediction`). It is combinational and is 0 whenever `resolve` is 0.
- jal, jalr and non-branch instructions never assert `misprediction` and never train the table.
- Train, on a clock edge where `resolve`=1: `bht[EXE_index]` increments if `EXE_taken`, otherwise decrements.
  - Saturation: 11 stays 11 when taken; 00 stays 00 when not taken.
  - Training uses `EXE_index`, never a recomputed index.
- Perf counters, on a clock edge where `resolve`=1:
  - `branch_count` increments.
  - `mispredict_count` increments when `misprediction`=1.
  - Both saturate at 32'hFFFFFFFF; they do not wrap.
- Read and update of the same index in the same cycle: lookup returns the pre-update value (no bypass).

## Timing
- Reset, asynchronous and immediate on assertion:
  - every BHT entry = 01;
  - GHR = 0;
  - `branch_count` = `mispredict_count` = 0.
- Resulting outputs during reset: `prediction`=0, `IF_index` follows `IF_PC`, and `misprediction` follows its inputs.
- Latency:
  - prediction is available in the same cycle as `IF_PC`;
  - misprediction is available in the same cycle as the EXE inputs;
  - a trained value is visible to lookups from the next cycle on.
- Reset deasserted mid-program: any training in flight is lost. No partial update is allowed.
- A stall with `EXE_valid`=0 changes no state.

## Configuration
- `BP_GSHARE_EN` defined:
  - an INDEX_BITS-wide global history register (GHR) is compiled in;
  - `IF_index` = `IF_PC[INDEX_BITS+1:2]` XOR GHR;
  - on each `resolve` edge, GHR <= {GHR[INDEX_BITS-2:0], `EXE_taken`}. GHR is updated non-speculatively, at resolve only.
- `BP_GSHARE_EN` undefined: there is no GHR, and indexing is PC-only as in Operation.

## Structure
- Shared package holds:
  - counter encoding constants SNT/WNT/WT/ST;
  - branch-class constants BR_NONE/BR_COND/BR_JAL/BR_JALR;
  - default `BHT_ENTRIES`.
- One sub-module, `sat_counter2`: a 2-bit up/down saturating next-state function with inputs `cur`, `inc` and output `nxt`. The BHT instantiates it once, on the update path.

## Test plan
- Reset, then lookup `IF_PC`=0x40: `prediction`=0 and `IF_index`=0x10. The counters read 0 after reset.
- Resolve branch at 0x40 taken twice with `EXE_prediction`=0:
  - first cycle `misprediction`=1;
  - `bht[0x10]` goes 01→10→11;
  - lookup of 0x40 then predicts 1;
  - `mispredict_count` ends at 1 if the second resolve uses `EXE_prediction`=1.
- Saturation: three more taken resolves leave `bht[0x10]`=11; one not-taken resolve gives 10 and `prediction` stays 1.
- `EXE_branch`=10 or 11 with `EXE_taken`≠`EXE_prediction`: `misprediction`=0, no counter change, `branch_count` unchanged.
- `EXE_valid`=0 with `EXE_branch`=01 and a mismatch: `misprediction`=0, no state change. Same-index lookup and update in one cycle returns the old value.
- With `BP_GSHARE_EN`:
  - resolve taken, taken → GHR=0b11;
  - lookup 0x40 → `IF_index`=0x10^0x03=0x13;
  - assert `rst` mid-cycle → GHR=0 and counters read 0 immediately.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared encodings for the branch predictor: counter states, branch classes, default table size.
package branch_predictor_pkg;

  localparam int BHT_ENTRIES_DEFAULT = 64;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_COND = 2'b01;
  localparam logic [1:0] BR_JAL  = 2'b10;
  localparam logic [1:0] BR_JALR = 2'b11;

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-lookup and execute-resolve bundle between the pipeline (master) and the predictor (slave).
interface branch_predictor_if
  import branch_predictor_pkg::*;
#(
  parameter int BHT_ENTRIES = BHT_ENTRIES_DEFAULT
) ();
  localparam int INDEX_BITS = $clog2(BHT_ENTRIES);

  logic [31:0]           IF_PC;
  logic                  prediction;
  logic [INDEX_BITS-1:0] IF_index;
  logic                  EXE_valid;
  logic [1:0]            EXE_branch;
  logic                  EXE_prediction;
  logic [INDEX_BITS-1:0] EXE_index;
  logic                  EXE_taken;
  logic                  misprediction;
  logic [31:0]           branch_count;
  logic [31:0]           mispredict_count;

  modport master (
    output IF_PC, EXE_valid, EXE_branch, EXE_prediction, EXE_index, EXE_taken,
    input  prediction, IF_index, misprediction, branch_count, mispredict_count
  );

  modport slave (
    input  IF_PC, EXE_valid, EXE_branch, EXE_prediction, EXE_index, EXE_taken,
    output prediction, IF_index, misprediction, branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit up/down saturating next-state function; purely combinational, no backpressure.
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] cur,
  input  logic       inc,
  output logic [1:0] nxt
);
  always_comb begin
    nxt = cur;
    if (inc) begin
      if (cur != ST) nxt = cur + 2'd1;
    end else begin
      if (cur != SNT) nxt = cur - 2'd1;
    end
  end
endmodule

// File: rtl/branch_predictor.sv
// 2-bit-counter BHT direction predictor; lookup and misprediction are combinational, training lands next cycle.
// No backpressure. Defining BP_GSHARE_EN XORs a resolve-time global history into the index.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int BHT_ENTRIES = BHT_ENTRIES_DEFAULT
) (
  input logic              clk,
  input logic              rst,
  branch_predictor_if.slave bp
);
  localparam int INDEX_BITS = $clog2(BHT_ENTRIES);

  logic [1:0]            bht [BHT_ENTRIES];
  logic [INDEX_BITS-1:0] pc_index;
  logic [INDEX_BITS-1:0] lookup_index;
  logic                  resolve;
  logic                  mispredict;
  logic [1:0]            trained;
  logic [31:0]           branch_cnt;
  logic [31:0]           mispred_cnt;
  logic                  unused_pc_bits;

  assign pc_index       = bp.IF_PC[INDEX_BITS+1:2];
  assign unused_pc_bits = ^{bp.IF_PC[31:INDEX_BITS+2], bp.IF_PC[1:0]};

`ifdef BP_GSHARE_EN
  logic [INDEX_BITS-1:0] ghr;

  // History advances only on resolved conditional branches, never speculatively at fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ghr <= '0;
    else if (resolve) ghr <= {ghr[INDEX_BITS-2:0], bp.EXE_taken};
  end

  assign lookup_index = pc_index ^ ghr;
`else
  assign lookup_index = pc_index;
`endif

  assign resolve    = bp.EXE_valid && (bp.EXE_branch == BR_COND);
  assign mispredict = resolve && (bp.EXE_taken != bp.EXE_prediction);

  sat_counter2 u_sat (
    .cur (bht[bp.EXE_index]),
    .inc (bp.EXE_taken),
    .nxt (trained)
  );

  // Training uses the index carried from fetch so gshare history drift cannot redirect the update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= WNT;
    end else if (resolve) begin
      bht[bp.EXE_index] <= trained;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else if (resolve) begin
      if (branch_cnt != '1) branch_cnt <= branch_cnt + 32'd1;
      if (mispredict && (mispred_cnt != '1)) mispred_cnt <= mispred_cnt + 32'd1;
    end
  end

  assign bp.IF_index         = lookup_index;
  assign bp.prediction       = bht[lookup_index][1];
  assign bp.misprediction    = mispredict;
  assign bp.branch_count     = branch_cnt;
  assign bp.mispredict_count = mispred_cnt;
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: a reference model queues expected outputs per driven cycle.
module tb_branch_predictor;
  import branch_predictor_pkg::*;

  localparam int N  = 64;
  localparam int IB = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_predictor_if #(.BHT_ENTRIES(N)) bp_if ();
  branch_predictor #(.BHT_ENTRIES(N)) dut (.clk(clk), .rst(rst), .bp(bp_if));

  int checks = 0;
  int errors = 0;

  logic [1:0]    bht_m [N];
  logic [IB-1:0] ghr_m;
  logic [31:0]   bc_m, mc_m;

  logic [31:0] exp_q [$];
  string       tag_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [IB-1:0] idx_m(input logic [31:0] pc);
`ifdef BP_GSHARE_EN
    return pc[IB+1:2] ^ ghr_m;
`else
    return pc[IB+1:2];
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) bht_m[i] = WNT;
    ghr_m = '0;
    bc_m  = '0;
    mc_m  = '0;
  endtask

  task automatic model_update(input logic v, input logic [1:0] br, input logic p,
                              input logic t, input logic [IB-1:0] eidx);
    if (v && br == BR_COND) begin
      if (t && bht_m[eidx] != ST) bht_m[eidx] = bht_m[eidx] + 2'd1;
      if (!t && bht_m[eidx] != SNT) bht_m[eidx] = bht_m[eidx] - 2'd1;
      if (bc_m != 32'hFFFF_FFFF) bc_m = bc_m + 1;
      if (t != p && mc_m != 32'hFFFF_FFFF) mc_m = mc_m + 1;
      ghr_m = {ghr_m[IB-2:0], t};
    end
  endtask

  task automatic push(input string tag, input logic [31:0] val);
    tag_q.push_back(tag);
    exp_q.push_back(val);
  endtask

  task automatic sample();
    logic [31:0] obs [5];
    obs[0] = 32'(bp_if.prediction);
    obs[1] = 32'(bp_if.IF_index);
    obs[2] = 32'(bp_if.misprediction);
    obs[3] = bp_if.branch_count;
    obs[4] = bp_if.mispredict_count;
    for (int i = 0; i < 5; i++) chk(tag_q.pop_front(), obs[i], exp_q.pop_front());
  endtask

  // One cycle: drive at negedge, compare combinational outputs, then let the edge train.
  task automatic step(input logic [31:0] pc, input logic v, input logic [1:0] br,
                      input logic p, input logic t, input logic [IB-1:0] eidx);
    logic [IB-1:0] li;
    @(negedge clk);
    bp_if.IF_PC          = pc;
    bp_if.EXE_valid      = v;
    bp_if.EXE_branch     = br;
    bp_if.EXE_prediction = p;
    bp_if.EXE_index      = eidx;
    bp_if.EXE_taken      = t;
    li = idx_m(pc);
    push("pred", 32'(bht_m[li][1]));
    push("idx", 32'(li));
    push("mis", 32'(v && br == BR_COND && t != p));
    push("bcnt", bc_m);
    push("mcnt", mc_m);
    #1 sample();
    @(posedge clk);
    model_update(v, br, p, t, eidx);
  endtask

  initial begin
    rst                  = 1'b1;
    bp_if.IF_PC          = 32'h40;
    bp_if.EXE_valid      = 1'b1;
    bp_if.EXE_branch     = BR_COND;
    bp_if.EXE_prediction = 1'b0;
    bp_if.EXE_index      = 6'h10;
    bp_if.EXE_taken      = 1'b1;
    model_reset();
    #3;
    chk("rst_pred", 32'(bp_if.prediction), 32'd0);
    chk("rst_idx", 32'(bp_if.IF_index), 32'h10);
    chk("rst_mis_follows", 32'(bp_if.misprediction), 32'd1);
    chk("rst_bcnt", bp_if.branch_count, 32'd0);
    chk("rst_mcnt", bp_if.mispredict_count, 32'd0);
    @(negedge clk);
    rst             = 1'b0;
    bp_if.EXE_valid = 1'b0;

    // Train 0x40 taken twice; second resolve already predicted taken.
    step(32'h40, 1'b1, BR_COND, 1'b0, 1'b1, idx_m(32'h40));
    step(32'h40, 1'b1, BR_COND, 1'b1, 1'b1, idx_m(32'h40));
`ifndef BP_GSHARE_EN
    #1;
    chk("tp_trained_pred", 32'(bp_if.prediction), 32'd1);
    chk("tp_mcnt", bp_if.mispredict_count, 32'd1);
    chk("tp_bcnt", bp_if.branch_count, 32'd2);
`endif
    repeat (3) step(32'h40, 1'b1, BR_COND, 1'b1, 1'b1, idx_m(32'h40));
    step(32'h40, 1'b1, BR_COND, 1'b1, 1'b0, idx_m(32'h40));
`ifndef BP_GSHARE_EN
    #1 chk("tp_sat_pred", 32'(bp_if.prediction), 32'd1);
`endif
    // Non-conditional classes and a stalled slot must not train or count.
    step(32'h40, 1'b1, BR_JAL,  1'b0, 1'b1, idx_m(32'h40));
    step(32'h40, 1'b1, BR_JALR, 1'b1, 1'b0, idx_m(32'h40));
    step(32'h40, 1'b1, BR_NONE, 1'b0, 1'b1, idx_m(32'h40));
    step(32'h40, 1'b0, BR_COND, 1'b0, 1'b1, idx_m(32'h40));
    // Same-index lookup and update: lookup sees the pre-update counter.
    step(32'h40, 1'b1, BR_COND, 1'b1, 1'b0, idx_m(32'h40));
`ifndef BP_GSHARE_EN
    #1 chk("tp_no_bypass_after", 32'(bp_if.prediction), 32'd0);
`endif

    for (int i = 0; i < 300; i++) begin
      logic [31:0]   pc;
      logic [IB-1:0] ei;
      pc = $urandom;
      ei = ($urandom_range(0, 1) == 0) ? idx_m(pc) : IB'($urandom_range(0, N - 1));
      step(pc, 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ei);
    end
    step(32'h40, 1'b0, BR_NONE, 1'b0, 1'b0, idx_m(32'h40));

`ifdef BP_GSHARE_EN
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(32'h40, 1'b1, BR_COND, 1'b0, 1'b1, idx_m(32'h40));
    step(32'h40, 1'b1, BR_COND, 1'b1, 1'b1, idx_m(32'h40));
    #1 chk("gs_idx", 32'(bp_if.IF_index), 32'h13);
`endif

    // Reset asserted between edges with a resolve pending.
    @(negedge clk);
    bp_if.IF_PC          = 32'h40;
    bp_if.EXE_valid      = 1'b1;
    bp_if.EXE_branch     = BR_COND;
    bp_if.EXE_prediction = 1'b1;
    bp_if.EXE_taken      = 1'b1;
    bp_if.EXE_index      = 6'h10;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_pred", 32'(bp_if.prediction), 32'd0);
    chk("mid_rst_idx", 32'(bp_if.IF_index), 32'h10);
    chk("mid_rst_bcnt", bp_if.branch_count, 32'd0);
    chk("mid_rst_mcnt", bp_if.mispredict_count, 32'd0);
    model_reset();
    @(negedge clk);
    rst             = 1'b0;
    bp_if.EXE_valid = 1'b0;
    step(32'h40, 1'b0, BR_NONE, 1'b0, 1'b0, idx_m(32'h40));

    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
